// File: rtl/pmod_debounce8.sv
// Eight-channel PMOD input conditioner: a two-flop synchroniser feeds a saturating
// stability counter on each channel, which produces clean levels and edge strobes.
module pmod_debounce8 #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Per-channel qualification: any return to the clean level restarts the count
  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int n = 0; n < WIDTH; n++) begin
      cnt_d[n] = '0;
      if (sync_q[n] == clean_q[n]) begin
        cnt_d[n] = '0;
      end else if (cnt_q[n] == CNT_MAX) begin
        clean_d[n] = sync_q[n];
        rise_d[n]  = sync_q[n];
        fall_d[n]  = ~sync_q[n];
        cnt_d[n]   = '0;
      end else begin
        cnt_d[n] = cnt_q[n] + CNT_W'(1);
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  // State registers; the synchroniser pair carries no logic between its flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q    <= '0;
      sync_q    <= '0;
      clean_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      meta_q    <= pin_in;
      sync_q    <= meta_q;
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  assign clean   = clean_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_pmod_debounce8.sv
// Directed bench for pmod_debounce8 with DEBOUNCE_CYCLES=4; expected output words
// are queued as each step is driven and compared just after the following edge.
module tb_pmod_debounce8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] pin_in = 8'h00;
  logic [7:0] clean, rise, fall;
  logic       changed;

  int checks = 0;
  int errors = 0;
  logic [24:0] exp_q [$];
  string       tag_q [$];

  pmod_debounce8 #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .pin_in (pin_in),
    .clean  (clean),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic compare_next();
    logic [24:0] e;
    logic [24:0] o;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {clean, rise, fall, changed};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed clean=%h rise=%h fall=%h changed=%b expected clean=%h rise=%h fall=%h changed=%b",
             t, o[24:17], o[16:9], o[8:1], o[0], e[24:17], e[16:9], e[8:1], e[0]);
    end
  endtask

  task automatic step(input logic [7:0] pin, input logic [7:0] ec, input logic [7:0] er,
                      input logic [7:0] ef, input logic ech, input string t);
    pin_in = pin;
    exp_q.push_back({ec, er, ef, ech});
    tag_q.push_back(t);
    @(posedge clk);
    #1;
    compare_next();
  endtask

  task automatic quiet(input logic [7:0] pin, input logic [7:0] ec, input int n, input string t);
    for (int i = 0; i < n; i++) begin
      step(pin, ec, 8'h00, 8'h00, 1'b0, t);
    end
  endtask

  task automatic async_check(input string t);
    exp_q.push_back(25'd0);
    tag_q.push_back(t);
    #1;
    compare_next();
  endtask

  initial begin
    pin_in = 8'hFF;
    #2;
    rst = 1'b1;
    async_check("reset_async");
    quiet(8'hFF, 8'h00, 2, "reset_hold");
    rst = 1'b0;

    quiet(8'hFF, 8'h00, 5, "por_wait");
    step(8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b1, "por_accept");
    step(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, "por_strobe_end");

    quiet(8'h00, 8'hFF, 5, "allfall_wait");
    step(8'h00, 8'h00, 8'h00, 8'hFF, 1'b1, "allfall_accept");
    step(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "allfall_end");

    quiet(8'h01, 8'h00, 5, "rise1_wait");
    step(8'h01, 8'h01, 8'h01, 8'h00, 1'b1, "rise1_accept");
    step(8'h01, 8'h01, 8'h00, 8'h00, 1'b0, "rise1_end");
    quiet(8'h00, 8'h01, 5, "fall1_wait");
    step(8'h00, 8'h00, 8'h00, 8'h01, 1'b1, "fall1_accept");

    quiet(8'h04, 8'h00, 3, "bounce_hi1");
    quiet(8'h00, 8'h00, 1, "bounce_lo");
    quiet(8'h04, 8'h00, 3, "bounce_hi2");
    quiet(8'h00, 8'h00, 8, "bounce_settle");

    quiet(8'hA5, 8'h00, 5, "a5_wait");
    step(8'hA5, 8'hA5, 8'hA5, 8'h00, 1'b1, "a5_accept");
    step(8'hA5, 8'hA5, 8'h00, 8'h00, 1'b0, "a5_end");
    quiet(8'h5A, 8'hA5, 5, "swap_wait");
    step(8'h5A, 8'h5A, 8'h5A, 8'hA5, 1'b1, "swap_accept");
    step(8'h5A, 8'h5A, 8'h00, 8'h00, 1'b0, "swap_end");
    quiet(8'h00, 8'h5A, 5, "clear_wait");
    step(8'h00, 8'h00, 8'h00, 8'h5A, 1'b1, "clear_accept");
    step(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "clear_end");

    quiet(8'h80, 8'h00, 3, "midcnt_pre");
    rst = 1'b1;
    async_check("midcnt_rst");
    quiet(8'h80, 8'h00, 2, "midcnt_hold");
    rst = 1'b0;
    quiet(8'h80, 8'h00, 5, "midcnt_wait");
    step(8'h80, 8'h80, 8'h80, 8'h00, 1'b1, "midcnt_accept");
    step(8'h80, 8'h80, 8'h00, 8'h00, 1'b0, "midcnt_end");

    quiet(8'h00, 8'h80, 3, "bnd_short");
    quiet(8'h80, 8'h80, 8, "bnd_restore");
    quiet(8'h00, 8'h80, 5, "bnd_fresh_wait");
    step(8'h00, 8'h00, 8'h00, 8'h80, 1'b1, "bnd_fresh_accept");
    step(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "bnd_fresh_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
